// File: rtl/hog_pkg.sv
// Shared geometry, state encoding and address helper for the HOG cell-fetch path.
// Frame geometry is in 8x8-pixel cells.
package hog_pkg;

    localparam int unsigned CELL_COLS = 40;
    localparam int unsigned CELL_ROWS = 30;
    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned MAX_ADDR  = CELL_COLS * CELL_ROWS - 1;
    localparam int unsigned COL_W     = $clog2(CELL_COLS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StRun   = ST_RUN,
        StDrain = ST_DRAIN
    } fetch_state_e;

    // Row-major linear cell address; fits ADDR_W bits at the default geometry.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ADDR_W-1:0] row,
                                                    input logic [ADDR_W-1:0] col);
        return row * ADDR_W'(CELL_COLS) + col;
    endfunction

endpackage

// File: rtl/hog_fetch_sched.sv
// Issues one cell fetch per cycle in row-major order, gated on line-buffer rows and on
// downstream FIFO credits; counts results back and pulses frame_done when the frame drains.
module hog_fetch_sched
    import hog_pkg::*;
#(
    parameter int unsigned ROW_W   = 5,
    parameter int unsigned CREDITS = 8,
    parameter int unsigned CRED_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ROW_W-1:0]  rows_avail,
    input  logic              credit_ret,
    input  logic              hog_valid,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              err_overrun
);

    localparam int unsigned ROWX_W = ROW_W + 1;

    fetch_state_e      state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] in_flight;

    logic              last_row;
    logic              last_col;
    logic              last_cell;
    logic              row_ready;
    logic              issue;
    logic              ret_ok;
    logic              valid_ok;
    logic              overrun;
    logic [ROWX_W-1:0] rows_needed;
    logic [ADDR_W-1:0] cur_addr;

    always_comb begin
        last_row    = (row == ROW_W'(CELL_ROWS - 1));
        last_col    = (col == COL_W'(CELL_COLS - 1));
        cur_addr    = cell_addr(ADDR_W'(row), ADDR_W'(col));
        last_cell   = (cur_addr == ADDR_W'(MAX_ADDR));
        // A cell's window reaches into the row below, except on the bottom row.
        rows_needed = {1'b0, row} + ROWX_W'(2);
        row_ready   = ({1'b0, rows_avail} >= rows_needed) ||
                      (last_row && (rows_avail == ROW_W'(CELL_ROWS)));
        issue       = (state == StRun) && (credits != '0) && row_ready;
        ret_ok      = credit_ret && (credits != CRED_W'(CREDITS));
        valid_ok    = hog_valid && (in_flight != '0);
        // The frame_done cycle still belongs to the finishing frame.
        overrun     = frame_start && ((state != StIdle) || frame_done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            row         <= '0;
            col         <= '0;
            credits     <= CRED_W'(CREDITS);
            in_flight   <= '0;
            fetch_req   <= 1'b0;
            fetch_addr  <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            fetch_req   <= issue;
            frame_done  <= 1'b0;
            err_overrun <= overrun;

            if (issue) begin
                fetch_addr <= cur_addr;
            end

            if (issue && !ret_ok) begin
                credits <= credits - CRED_W'(1);
            end else if (!issue && ret_ok) begin
                credits <= credits + CRED_W'(1);
            end

            if (issue && !valid_ok) begin
                in_flight <= in_flight + CRED_W'(1);
            end else if (!issue && valid_ok) begin
                in_flight <= in_flight - CRED_W'(1);
            end

            unique case (state)
                StIdle: begin
                    if (frame_start && !frame_done) begin
                        state <= StRun;
                        row   <= '0;
                        col   <= '0;
                        busy  <= 1'b1;
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (last_cell) begin
                            state <= StDrain;
                        end
                        if (last_col) begin
                            col <= '0;
                            if (!last_row) begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (in_flight == '0) begin
                        state      <= StIdle;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
